bf16_divider: RTL and testbench
===============================

Name: bf16_divider

Overview:
Iterative BF16 divider, result = num1 / num2. It is the inverse-operation companion to the team's combinational BF16 multiplier and uses the same operand format and the same exception-flag set. Mantissas are divided by a 9-step restoring shift-subtract loop under a start/done handshake. Latency is fixed for every operand class.

Parameters:
EXP_BIAS, 127, BF16 exponent bias.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
num1  input  16  dividend, BF16 {sign, exp[7:0], mant[6:0]}
num2  input  16  divisor, BF16
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; result/flags valid
result  output  16  quotient, BF16
zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf  output  1 each  exception flags, valid with done

Behaviour:
- Reset: the interface is synchronous active-low (rst_n sampled on the clk edge). Effect at that edge: state=IDLE; busy, done, result and all flags go to 0. This holds mid-operation too; the in-flight operation is discarded with no done.
- FSM: IDLE -> DIV (9 edges, iteration counter 0..8) -> NORM -> DONE -> IDLE.
- Edge E0 (start=1 in IDLE):
  - register num1, num2 and s = sign1^sign2;
  - R = {1,mant1} (9b), D = {1,mant2};
  - classify both operands;
  - clear result and flags.
- Edges E1..E9, one quotient bit per edge, MSB first:
  - q = (R >= D);
  - R = (R - q*D) << 1;
  - Q = {Q[7:0], q}.
- Edge E10 (NORM):
  - if Q[8]=1: mant = Q[7:1], e = e1 - e2 + EXP_BIAS;
  - else: mant = Q[6:0], e = e1 - e2 + EXP_BIAS - 1;
  - e is a 10-bit signed value;
  - result and flags are registered here, and done=1 in the following cycle.
- Edge E11: back to IDLE, done=0. start is ignored while busy=1, including the DONE cycle, so the earliest next accept is E11.
- result and flags hold until the next accepted start.
- Special operands:
  - Still occupy the full 10-edge latency; iteration results are discarded.
  - exp==0 means zero (subnormals flushed).
  - exp==FF with mant==0 means infinity.
  - exp==FF with mant!=0 means NaN: mant[6]=1 is quiet, else signaling.
- Priority, first match wins:
  1. any sNaN -> 16'hFF81, sNaN=1
  2. any qNaN -> 16'hFFC1, qNaN=1
  3. 0/0 or inf/inf -> 16'hFFC1, qNaN=1
  4. inf/x -> {s,8'hFF,7'h0}, positive_inf or negative_inf per s
  5. x/inf -> {s,15'h0}, zero=1
  6. x/0 (x nonzero finite) -> signed inf, inf flag per s
  7. 0/x -> {s,15'h0}, zero=1
- Normal-path range:
  - e >= 255 -> overflow=1, result = signed inf, inf flag per s;
  - e <= 0 -> underflow=1, zero=1, result {s,15'h0};
  - else result = {s, e[7:0], mant}.
- Rounding: truncation (toward zero); the remainder is discarded.
- Exactly one of the flag groups is set per operation: none for an in-range normal result, or else one NaN flag, one inf flag, or zero (with optional underflow/overflow as stated above).

Decomposition:
- Shared package bf16_pkg:
  - field widths and EXP_BIAS;
  - QNAN_CANON=16'hFFC1, SNAN_CANON=16'hFF81;
  - POS_INF=16'h7F80, NEG_INF=16'hFF80;
  - operand-class enum {ZERO, NORMAL, INF, QNAN, SNAN};
  - FSM state enum.
- One sub-module bf16_classify: combinational, maps a 16-bit word to its class. It is instantiated twice here and is reusable by the multiplier.

Test Plan:
1. 0x4040 / 0x4000 (3/2), start at E0 -> done high only in the cycle after E10; result 0x3FC0; all flags 0; busy=1 from E0 through E11.
2. 0x3F80 / 0x4040 (1/3) -> 0x3EAA (truncated, not 0x3EAB), flags 0. Then 0x4000 / 0x3F80 -> 0x4000 (Q[8]=1 path).
3. 0x4000 / 0x0000 -> 0x7F80, positive_inf=1; 0xC000 / 0x0000 -> 0xFF80, negative_inf=1; 0x0000 / 0x0000 -> 0xFFC1, qNaN=1; 0x7F81 / 0x7FC1 -> 0xFF81, sNaN=1 (sNaN priority).
4. 0x7F00 / 0x0080 -> overflow=1, positive_inf=1, 0x7F80; 0x0080 / 0x7F00 -> underflow=1, zero=1, 0x0000; 0x3F80 / 0xFF80 -> 0x8000, zero=1.
5. Handshake:
   - start pulsed at E3 and again during DONE -> both ignored;
   - first result unchanged;
   - back-to-back start at E11 -> second done after E21.
6. rst_n=0 at E5 mid-DIV -> after that edge busy=0, done=0, result=0, flags 0; no done pulse follows; the next start completes normally.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared BF16 definitions: field widths, canonical special values,
// operand classes, exception flag bundle and the divider FSM states.
package bf16_pkg;

  localparam int BF16_W        = 16;
  localparam int EXP_W         = 8;
  localparam int MANT_W        = 7;
  localparam int BF16_EXP_BIAS = 127;

  // Number of quotient bits produced by the restoring loop (hidden bit + mantissa + 1)
  localparam int DIV_STEPS = 9;

  localparam logic [EXP_W-1:0]  EXP_MAX    = 8'hFF;
  localparam logic [BF16_W-1:0] QNAN_CANON = 16'hFFC1;
  localparam logic [BF16_W-1:0] SNAN_CANON = 16'hFF81;
  localparam logic [BF16_W-1:0] POS_INF    = 16'h7F80;
  localparam logic [BF16_W-1:0] NEG_INF    = 16'hFF80;

  typedef enum logic [2:0] {
    ZERO,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } bf16_class_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_DONE
  } div_state_e;

  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
    logic qnan;
    logic snan;
    logic pos_inf;
    logic neg_inf;
  } bf16_flags_t;

  // Infinity with the given sign
  function automatic logic [BF16_W-1:0] signed_inf(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

  // Zero with the given sign
  function automatic logic [BF16_W-1:0] signed_zero(input logic s);
    return {s, {(BF16_W-1){1'b0}}};
  endfunction

  // Exception flags for an infinite result of the given sign
  function automatic bf16_flags_t inf_flags(input logic s);
    bf16_flags_t f;
    f         = '0;
    f.pos_inf = ~s;
    f.neg_inf = s;
    return f;
  endfunction

endpackage

// File: rtl/bf16_classify.sv
// Combinational BF16 operand classifier. Subnormals are flushed to ZERO;
// NaNs are split into quiet/signaling by the top mantissa bit.
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0] word,
  output logic              sign,
  output bf16_class_e       cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  assign sign   = word[BF16_W-1];
  assign exp_f  = word[BF16_W-2:MANT_W];
  assign mant_f = word[MANT_W-1:0];

  // Decode exponent/mantissa into an operand class
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (exp_f == EXP_MAX) begin
      if (mant_f == '0) begin
        cls = INF;
      end else if (mant_f[MANT_W-1]) begin
        cls = QNAN;
      end else begin
        cls = SNAN;
      end
    end
  end

endmodule

// File: rtl/bf16_divider.sv
// Iterative BF16 divider: result = num1 / num2.
// One quotient bit per cycle from a restoring shift-subtract loop, then a
// normalise/exception cycle; every operation takes the same number of cycles.
module bf16_divider
  import bf16_pkg::*;
#(
  parameter int EXP_BIAS = BF16_EXP_BIAS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BF16_W-1:0] num1,
  input  logic [BF16_W-1:0] num2,
  output logic              busy,
  output logic              done,
  output logic [BF16_W-1:0] result,
  output logic              zero,
  output logic              underflow,
  output logic              overflow,
  output logic              qNaN,
  output logic              sNaN,
  output logic              positive_inf,
  output logic              negative_inf
);

  localparam logic [9:0] BIAS10   = 10'(EXP_BIAS);
  localparam logic [3:0] LAST_CNT = 4'(DIV_STEPS - 1);

  div_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Captured operands: index 0 = dividend, index 1 = divisor
  logic [1:0][BF16_W-1:0] ops_q, ops_d;
  logic [9:0] rem_q, rem_d;
  logic [8:0] quo_q, quo_d;
  logic [BF16_W-1:0] result_q, result_d;
  bf16_flags_t flags_q, flags_d;

  logic        op_sign [2];
  bf16_class_e op_cls  [2];

  // Classify both captured operands with one reusable classifier each
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
      bf16_classify u_classify (
        .word (ops_q[gi]),
        .sign (op_sign[gi]),
        .cls  (op_cls[gi])
      );
    end
  endgenerate

  logic        sign_res;
  logic [8:0]  div_w;
  logic        q_bit;
  logic [9:0]  rem_sub;
  logic [9:0]  exp_raw;
  logic [6:0]  mant_n;
  logic        any_snan;
  logic        any_qnan;
  logic        accept;

  // Datapath helpers shared by the DIV and NORM states
  always_comb begin
    sign_res = op_sign[0] ^ op_sign[1];
    div_w    = {1'b1, ops_q[1][MANT_W-1:0]};
    q_bit    = (rem_q >= {1'b0, div_w});
    rem_sub  = rem_q - (q_bit ? {1'b0, div_w} : 10'd0);
    // Without a leading quotient bit the result needs one extra left shift,
    // which is paid for by one less in the exponent.
    exp_raw  = {2'b00, ops_q[0][BF16_W-2:MANT_W]}
             - {2'b00, ops_q[1][BF16_W-2:MANT_W]}
             + BIAS10
             - {9'd0, ~quo_q[8]};
    mant_n   = quo_q[8] ? quo_q[7:1] : quo_q[6:0];
    any_snan = (op_cls[0] == SNAN) || (op_cls[1] == SNAN);
    any_qnan = (op_cls[0] == QNAN) || (op_cls[1] == QNAN);
  end

  // Next-state, iteration and result/flag computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    flags_d  = flags_q;
    accept   = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept = start;
      end
      S_DIV: begin
        quo_d = {quo_q[7:0], q_bit};
        rem_d = rem_sub << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        state_d  = S_DONE;
        result_d = '0;
        flags_d  = '0;
        if (any_snan) begin
          result_d     = SNAN_CANON;
          flags_d.snan = 1'b1;
        end else if (any_qnan) begin
          result_d     = QNAN_CANON;
          flags_d.qnan = 1'b1;
        end else if ((op_cls[0] == ZERO && op_cls[1] == ZERO) ||
                     (op_cls[0] == INF  && op_cls[1] == INF)) begin
          result_d     = QNAN_CANON;
          flags_d.qnan = 1'b1;
        end else if (op_cls[0] == INF) begin
          result_d = signed_inf(sign_res);
          flags_d  = inf_flags(sign_res);
        end else if (op_cls[1] == INF) begin
          result_d     = signed_zero(sign_res);
          flags_d.zero = 1'b1;
        end else if (op_cls[1] == ZERO) begin
          result_d = signed_inf(sign_res);
          flags_d  = inf_flags(sign_res);
        end else if (op_cls[0] == ZERO) begin
          result_d     = signed_zero(sign_res);
          flags_d.zero = 1'b1;
        end else if ($signed(exp_raw) >= 10'sd255) begin
          result_d         = signed_inf(sign_res);
          flags_d          = inf_flags(sign_res);
          flags_d.overflow = 1'b1;
        end else if ($signed(exp_raw) <= 10'sd0) begin
          result_d          = signed_zero(sign_res);
          flags_d.zero      = 1'b1;
          flags_d.underflow = 1'b1;
        end else begin
          result_d = {sign_res, exp_raw[7:0], mant_n};
        end
      end
      S_DONE: begin
        // The edge leaving DONE is the first edge at which a new request
        // can be taken, so a start here chains straight into the next op.
        state_d = S_IDLE;
        accept  = start;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d  = S_DIV;
      cnt_d    = '0;
      ops_d[0] = num1;
      ops_d[1] = num2;
      rem_d    = {3'b001, num1[MANT_W-1:0]};
      quo_d    = '0;
      result_d = '0;
      flags_d  = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ops_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ops_q    <= ops_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign result       = result_q;
  assign zero         = flags_q.zero;
  assign underflow    = flags_q.underflow;
  assign overflow     = flags_q.overflow;
  assign qNaN         = flags_q.qnan;
  assign sNaN         = flags_q.snan;
  assign positive_inf = flags_q.pos_inf;
  assign negative_inf = flags_q.neg_inf;

endmodule

// File: tb/tb_bf16_divider.sv
// Directed bench for bf16_divider: hand-computed quotients, exception
// priorities, range limits, handshake timing and mid-operation reset.
module tb_bf16_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num1 = '0;
  logic [15:0] num2 = '0;
  logic        busy, done;
  logic [15:0] result;
  logic        zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Flag vector order: {zero, underflow, overflow, qNaN, sNaN, +inf, -inf}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_ZERO = 7'b1000000;
  localparam logic [6:0] F_UNF  = 7'b0100000;
  localparam logic [6:0] F_OVF  = 7'b0010000;
  localparam logic [6:0] F_QN   = 7'b0001000;
  localparam logic [6:0] F_SN   = 7'b0000100;
  localparam logic [6:0] F_PI   = 7'b0000010;
  localparam logic [6:0] F_NI   = 7'b0000001;

  bf16_divider dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num1         (num1),
    .num2         (num2),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .zero         (zero),
    .underflow    (underflow),
    .overflow     (overflow),
    .qNaN         (qNaN),
    .sNaN         (sNaN),
    .positive_inf (positive_inf),
    .negative_inf (negative_inf)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] flags_now();
    return {zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done with a cycle budget; returns edges taken
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  // One full operation from E0 through E11 with all timing checks
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic [6:0] exp_flags);
    int lat;
    bit busy_ok;
    num1 = a;
    num2 = b;
    start = 1'b1;
    tick();                                  // E0
    start = 1'b0;
    check_eq({tag, " busy@E0"}, {15'd0, busy}, 16'd1);
    wait_done(lat, busy_ok);
    check_eq({tag, " latency"}, 16'(lat), 16'd10);
    check_eq({tag, " busy held"}, {15'd0, busy_ok}, 16'd1);
    check_eq({tag, " result"}, result, exp_res);
    check_eq({tag, " flags"}, {9'd0, flags_now()}, {9'd0, exp_flags});
    $display("op %s: %h / %h -> %h flags %b (lat %0d)", tag, a, b, result, flags_now(), lat);
    tick();                                  // E11
    check_eq({tag, " idle@E11"}, {14'd0, done, busy}, 16'd0);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int done_seen;

    // Reset state
    repeat (3) tick();
    check_eq("reset busy/done", {14'd0, busy, done}, 16'd0);
    check_eq("reset result", result, 16'h0000);
    check_eq("reset flags", {9'd0, flags_now()}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Normal quotients
    run_op("3/2",     16'h4040, 16'h4000, 16'h3FC0, F_NONE);
    run_op("1/3",     16'h3F80, 16'h4040, 16'h3EAA, F_NONE);
    run_op("2/1",     16'h4000, 16'h3F80, 16'h4000, F_NONE);
    run_op("-5/2.5",  16'hC0A0, 16'h4020, 16'hC000, F_NONE);

    // Special operands and priority
    run_op("2/0",     16'h4000, 16'h0000, 16'h7F80, F_PI);
    run_op("-2/0",    16'hC000, 16'h0000, 16'hFF80, F_NI);
    run_op("0/0",     16'h0000, 16'h0000, 16'hFFC1, F_QN);
    run_op("snan",    16'h7F81, 16'h7FC1, 16'hFF81, F_SN);
    run_op("qnan",    16'h4000, 16'h7FC0, 16'hFFC1, F_QN);
    run_op("inf/inf", 16'h7F80, 16'hFF80, 16'hFFC1, F_QN);
    run_op("-inf/2",  16'hFF80, 16'h4000, 16'hFF80, F_NI);
    run_op("0/-2",    16'h0000, 16'hC000, 16'h8000, F_ZERO);

    // Range limits
    run_op("ovf",     16'h7F00, 16'h0080, 16'h7F80, F_OVF | F_PI);
    run_op("unf",     16'h0080, 16'h7F00, 16'h0000, F_UNF | F_ZERO);
    run_op("1/-inf",  16'h3F80, 16'hFF80, 16'h8000, F_ZERO);

    // Handshake: starts while busy are ignored, start at E11 chains
    num1 = 16'h4040; num2 = 16'h4000; start = 1'b1;
    tick();                                  // E0
    start = 1'b0;
    tick(); tick();                          // E1, E2
    num1 = 16'h3F80; num2 = 16'h4040; start = 1'b1;
    tick();                                  // E3: ignored
    start = 1'b0; num1 = 16'h4040; num2 = 16'h4000;
    repeat (6) tick();                       // E4..E9
    num1 = 16'h4000; num2 = 16'h3F80; start = 1'b1;
    tick();                                  // E10: ignored (busy)
    check_eq("hs done@E10", {15'd0, done}, 16'd1);
    check_eq("hs first result", result, 16'h3FC0);
    check_eq("hs first flags", {9'd0, flags_now()}, 16'd0);
    $display("op hs-first: 4040 / 4000 -> %h flags %b", result, flags_now());
    num1 = 16'h3F80; num2 = 16'h4040;
    tick();                                  // E11: accepted
    start = 1'b0;
    check_eq("hs E11 busy/done", {14'd0, busy, done}, 16'b10);
    check_eq("hs E11 cleared", result, 16'h0000);
    wait_done(lat, busy_ok);
    check_eq("hs second latency", 16'(lat), 16'd10);
    check_eq("hs second result", result, 16'h3EAA);
    $display("op hs-second: 3f80 / 4040 -> %h flags %b (lat %0d)", result, flags_now(), lat);
    tick();
    check_eq("hs idle", {15'd0, busy}, 16'd0);

    // Reset in the middle of DIV
    num1 = 16'h4040; num2 = 16'h4000; start = 1'b1;
    tick();                                  // E0
    start = 1'b0;
    repeat (4) tick();                       // E1..E4
    rst_n = 1'b0;
    tick();                                  // E5: reset
    rst_n = 1'b1;
    check_eq("rst busy/done", {14'd0, busy, done}, 16'd0);
    check_eq("rst result", result, 16'h0000);
    check_eq("rst flags", {9'd0, flags_now()}, 16'd0);
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) done_seen++;
    end
    check_eq("rst no done", 16'(done_seen), 16'd0);
    $display("op reset: aborted mid-DIV, done pulses after %0d", done_seen);
    run_op("after rst", 16'h4000, 16'h3F80, 16'h4000, F_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
